// File: rtl/scan_index_gen_if.sv
// Scan index generator bus: scan controls from the controller, decoder index
// and strobes back from the generator.
interface scan_index_gen_if #(
    parameter int PRESCALE_W = 16
);
    logic                  en_i;
    logic [PRESCALE_W-1:0] period_i;
    logic [7:0]            mask_i;
    logic [2:0]            index_o;
    logic                  valid_o;
    logic                  step_o;
    logic                  wrap_o;

    // Controller side: issues enable, dwell period and position mask.
    modport master (
        output en_i, period_i, mask_i,
        input  index_o, valid_o, step_o, wrap_o
    );

    // Generator side: consumes controls, produces index and strobes.
    modport slave (
        input  en_i, period_i, mask_i,
        output index_o, valid_o, step_o, wrap_o
    );
endinterface

// File: rtl/scan_index_gen.sv
// Scan index generator: steps a 3-bit decoder index cyclically through the
// positions enabled in mask_i, holding each for period_i+1 cycles.
// Optional feature macro SCAN_BLANK_EN: inserts BLANK_CYCLES blanking cycles
// (valid_o low) after every index change.
module scan_index_gen #(
    parameter int PRESCALE_W   = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    scan_index_gen_if.slave  bus
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, RUN, HOLD, BLANK} state_t;
    localparam logic [PRESCALE_W-1:0] BLANK_LAST = PRESCALE_W'(BLANK_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    // Blanking length only matters when blanking is built in.
    logic unused_blank_cfg;
    assign unused_blank_cfg = ^BLANK_CYCLES;
`endif

    state_t                state_q, state_d;
    logic [2:0]            index_q, index_d;
    logic                  valid_q, valid_d;
    logic                  step_q, step_d;
    logic                  wrap_q, wrap_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    logic [2:0] first_idx;
    logic [2:0] next_idx;
    logic       mask_nz;
    logic       cur_en;

    // Circular search for the next enabled position strictly after cur;
    // returns cur itself when it is the only enabled position.
    function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] cand;
        logic [2:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = cur + 3'(k);
            if (!found && m[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Search candidates: lowest enabled position (search after 7) and successor.
    always_comb begin
        first_idx = next_after(3'd7, bus.mask_i);
        next_idx  = next_after(index_q, bus.mask_i);
        mask_nz   = |bus.mask_i;
        cur_en    = bus.mask_i[index_q];
    end

    // Next-state and output decode; every index change pulses step_d.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (!bus.en_i) begin
            state_d = IDLE;
            index_d = 3'd0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mask_nz) begin
                        index_d = first_idx;
                        step_d  = 1'b1;
                        cnt_d   = '0;
`ifdef SCAN_BLANK_EN
                        state_d = BLANK;
                        valid_d = 1'b0;
`else
                        state_d = RUN;
                        valid_d = 1'b1;
`endif
                    end else begin
                        state_d = HOLD;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    valid_d = 1'b0;
                    if (mask_nz) begin
                        index_d = next_idx;
                        step_d  = 1'b1;
                        wrap_d  = (next_idx <= index_q);
                        cnt_d   = '0;
`ifdef SCAN_BLANK_EN
                        state_d = BLANK;
`else
                        state_d = RUN;
                        valid_d = 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (!mask_nz) begin
                        state_d = HOLD;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else if (!cur_en || (cnt_q >= bus.period_i)) begin
                        // Terminal count, or current position masked out: force a step.
                        index_d = next_idx;
                        step_d  = 1'b1;
                        wrap_d  = (next_idx <= index_q);
                        cnt_d   = '0;
`ifdef SCAN_BLANK_EN
                        state_d = BLANK;
                        valid_d = 1'b0;
`else
                        valid_d = cur_en;
`endif
                    end else begin
                        cnt_d   = cnt_q + PRESCALE_W'(1);
                        valid_d = 1'b1;
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    valid_d = 1'b0;
                    if (!mask_nz) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q >= BLANK_LAST) begin
                        cnt_d = '0;
                        if (cur_en) begin
                            state_d = RUN;
                            valid_d = 1'b1;
                        end else begin
                            // Position lost during blanking: step straight on.
                            index_d = next_idx;
                            step_d  = 1'b1;
                            wrap_d  = (next_idx <= index_q);
                        end
                    end else begin
                        cnt_d = cnt_q + PRESCALE_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    index_d = 3'd0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; async assert, sync release reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            index_q <= 3'd0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.index_o = index_q;
    assign bus.valid_o = valid_q;
    assign bus.step_o  = step_q;
    assign bus.wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench for scan_index_gen: the driver applies inputs each cycle and
// queues the outputs a position-list reference model predicts; a monitor pops
// and compares after every rising edge.
module tb_scan_index_gen;

    localparam int PW = 16;
`ifdef SCAN_BLANK_EN
    localparam int TB_BLANK = 2;
`else
    localparam int TB_BLANK = 4;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HOLD  = 2;
    localparam int M_BLANK = 3;

    typedef struct {
        logic [2:0] idx;
        logic       v;
        logic       s;
        logic       w;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int   m_mode;
    int   m_pos;
    int   m_elapsed;
    int   m_blank_left;
    bit   m_valid;
    bit   m_step;
    bit   m_wrap;

    scan_index_gen_if #(.PRESCALE_W(PW)) bus ();

    scan_index_gen #(
        .PRESCALE_W  (PW),
        .BLANK_CYCLES(TB_BLANK)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // First enabled position after p in ascending order, wrapping to the lowest.
    function automatic int pos_after(input int p, input logic [7:0] m);
        int lst[$];
        for (int i = 0; i < 8; i++)
            if (m[i]) lst.push_back(i);
        foreach (lst[j])
            if (lst[j] > p) return lst[j];
        return lst[0];
    endfunction

    task automatic move_to(input int np, input bit w);
        m_pos     = np;
        m_step    = 1'b1;
        m_wrap    = w;
        m_elapsed = 0;
`ifdef SCAN_BLANK_EN
        m_mode       = M_BLANK;
        m_valid      = 1'b0;
        m_blank_left = TB_BLANK;
`else
        m_mode  = M_RUN;
        m_valid = 1'b1;
`endif
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_elapsed = 0; m_blank_left = 0;
        m_valid = 0; m_step = 0; m_wrap = 0;
    endtask

    // Advance the model by one clock edge with the inputs sampled at it.
    task automatic model_edge(input bit en, input int per, input logic [7:0] m);
        int np;
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (m != 0) move_to(pos_after(-1, m), 1'b0);
                else begin m_mode = M_HOLD; m_valid = 1'b0; end
            end
            M_HOLD: begin
                if (m != 0) begin
                    np = pos_after(m_pos, m);
                    move_to(np, np <= m_pos);
                end
            end
            M_RUN: begin
                if (m == 0) begin
                    m_mode = M_HOLD; m_valid = 1'b0;
                end else if (!m[m_pos]) begin
                    np = pos_after(m_pos, m);
                    move_to(np, np <= m_pos);
                    m_valid = 1'b0;
                end else if (m_elapsed >= per) begin
                    np = pos_after(m_pos, m);
                    move_to(np, np <= m_pos);
                end else begin
                    m_elapsed++;
                    m_valid = 1'b1;
                end
            end
            default: begin
                if (m == 0) begin
                    m_mode = M_HOLD; m_valid = 1'b0;
                end else begin
                    m_blank_left--;
                    if (m_blank_left == 0) begin
                        if (m[m_pos]) begin
                            m_mode = M_RUN; m_valid = 1'b1; m_elapsed = 0;
                        end else begin
                            np = pos_after(m_pos, m);
                            move_to(np, np <= m_pos);
                        end
                    end
                end
            end
        endcase
    endtask

    // Apply one cycle of stimulus and queue the predicted response.
    task automatic drive(input bit en, input int per, input logic [7:0] m);
        exp_t e;
        @(negedge clk);
        bus.en_i     = en;
        bus.period_i = PW'(per);
        bus.mask_i   = m;
        model_edge(en, per, m);
        e.idx = 3'(m_pos);
        e.v   = m_valid;
        e.s   = m_step;
        e.w   = m_wrap;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.index_o !== e.idx || bus.valid_o !== e.v ||
                    bus.step_o !== e.s || bus.wrap_o !== e.w) begin
                    n_fail++;
                    $display("FAIL out @%0t: got idx=%0d v=%0b s=%0b w=%0b expected idx=%0d v=%0b s=%0b w=%0b",
                             $time, bus.index_o, bus.valid_o, bus.step_o, bus.wrap_o,
                             e.idx, e.v, e.s, e.w);
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_index"}, int'(bus.index_o), 0);
        chk({tag, "_valid"}, int'(bus.valid_o), 0);
        chk({tag, "_step"},  int'(bus.step_o), 0);
        chk({tag, "_wrap"},  int'(bus.wrap_o), 0);
    endtask

    initial begin
        logic [7:0] mask;
        int         per;
        bit         en;

        rst_n        = 1'b0;
        bus.en_i     = 1'b0;
        bus.period_i = '0;
        bus.mask_i   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Basic scan: all positions, period 3
        drive(0, 3, 8'hFF);
        for (int i = 0; i < 40; i++) drive(1, 3, 8'hFF);
        // Skip pattern, period 0
        drive(0, 0, 8'hA4);
        for (int i = 0; i < 12; i++) drive(1, 0, 8'hA4);
        // Single bit, then empty mask, then bit 0
        for (int i = 0; i < 10; i++) drive(1, 2, 8'h08);
        for (int i = 0; i < 4; i++)  drive(1, 2, 8'h00);
        for (int i = 0; i < 6; i++)  drive(1, 2, 8'h01);
        // Enable with empty mask goes to hold, then release
        drive(0, 1, 8'h00);
        for (int i = 0; i < 3; i++)  drive(1, 1, 8'h00);
        for (int i = 0; i < 8; i++)  drive(1, 1, 8'h03);
        // Mask-out mid-dwell at count 2 of index 4
        drive(0, 9, 8'hFF);
        for (int i = 0; i < 200; i++) begin
            drive(1, 9, 8'hFF);
            if (m_mode == M_RUN && m_pos == 4 && m_elapsed == 2) break;
        end
        for (int i = 0; i < 6; i++) drive(1, 9, 8'hEF);
        // Period shrinking below the running count
        for (int i = 0; i < 5; i++) drive(1, 9, 8'hFF);
        for (int i = 0; i < 4; i++) drive(1, 1, 8'hFF);

        // Randomized traffic
        mask = 8'h5A; per = 2; en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 8'h00;
                    1: mask = 8'(1 << $urandom_range(0, 7));
                    default: mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 14) == 0) mask[m_pos] = 1'b0;
            if ($urandom_range(0, 7) == 0)
                per = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
            drive(en, per, mask);
        end

        // Asynchronous reset mid-run at index 5
        drive(0, 0, 8'hFF);
        for (int i = 0; i < 100; i++) begin
            drive(1, 0, 8'hFF);
            if (m_mode == M_RUN && m_pos == 5) break;
        end
        @(negedge clk);
        chk("pre_reset_index", int'(bus.index_o), 5);
        bus.en_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(1, 1, 8'h30);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
